// File: rtl/deserializer_pkg.sv
// -----------------------------------------------------------------------------
// deserializer_pkg
// Shared definitions for the serial-to-parallel receiver: default word and
// length-code widths and the collector state encoding.
// Optional feature macro used by the design: DESERIALIZER_GAP_FLUSH_EN
// -----------------------------------------------------------------------------
package deserializer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int MOD_W_DEF  = $clog2(DATA_W_DEF);

  typedef enum logic [0:0] {
    IDLE_S    = 1'b0,
    COLLECT_S = 1'b1
  } deser_state_t;

endpackage

// File: rtl/deserializer_out_buf.sv
// -----------------------------------------------------------------------------
// deserializer_out_buf
// One-entry hold register between the bit collector and the parallel sink.
// A load is accepted when the register is empty or its word is being taken in
// the same cycle; otherwise the incoming word is dropped and o_overflow pulses.
// Ports:
//   clk_i, srst_i        clock, asynchronous active-high reset
//   i_load               collector has a completed word this cycle
//   i_word, i_mod        completed word and its length code
//   i_ready              sink ready
//   o_data, o_mod        held word / length code (zero when empty)
//   o_val                hold register occupied
//   o_overflow           one-cycle pulse when a completed word is dropped
// -----------------------------------------------------------------------------
module deserializer_out_buf #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic [MOD_W-1:0]  i_mod,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [MOD_W-1:0]  o_mod,
  output logic              o_val,
  output logic              o_overflow
);

  logic [DATA_W-1:0] r_data;
  logic [MOD_W-1:0]  r_mod;
  logic              r_val;
  logic              r_ovf;
  logic              w_accept;

  assign w_accept = r_val & i_ready;

  // Hold register: load on free slot (or same-cycle accept), drop and flag otherwise.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_data <= {DATA_W{1'b0}};
      r_mod  <= {MOD_W{1'b0}};
      r_val  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (i_load) begin
      if (!r_val || w_accept) begin
        r_data <= i_word;
        r_mod  <= i_mod;
        r_val  <= 1'b1;
        r_ovf  <= 1'b0;
      end else begin
        // Slot occupied and not drained: keep the old word, report the loss.
        r_ovf  <= 1'b1;
      end
    end else begin
      r_ovf <= 1'b0;
      if (w_accept) begin
        r_data <= {DATA_W{1'b0}};
        r_mod  <= {MOD_W{1'b0}};
        r_val  <= 1'b0;
      end else begin
        r_val  <= r_val;
      end
    end
  end

  assign o_data     = r_data;
  assign o_mod      = r_mod;
  assign o_val      = r_val;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
// Serial-to-parallel receiver. Collects MSB-first bits qualified by
// ser_data_val_i into DATA_W-bit words and presents them through a one-entry
// ready/valid hold register (deserializer_out_buf).
// Optional feature: `define DESERIALIZER_GAP_FLUSH_EN to flush a partial word
// (right-aligned, length code = bits held) when the valid strobe drops
// mid-word. Without it gaps are ignored and only full words are emitted.
// Ports:
//   clk_i, srst_i              clock, asynchronous active-high reset
//   ser_data_i, ser_data_val_i serial bit and its qualifier
//   deser_data_o               received word
//   deser_data_mod_o           length code (0 = full DATA_W bits, else N bits)
//   deser_data_val_o           output word valid
//   deser_data_ready_i         sink accepts when valid & ready
//   busy_o                     a word is being collected
//   overflow_o                 one-cycle pulse when a completed word is dropped
// -----------------------------------------------------------------------------
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  input  logic              deser_data_ready_i,
  output logic              busy_o,
  output logic              overflow_o
);

`ifdef DESERIALIZER_GAP_FLUSH_EN
  // Mask with the low n bits set; removes stale bits of an earlier word.
  function automatic logic [DATA_W-1:0] low_mask(input logic [MOD_W-1:0] n);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction
`endif

  deser_state_t      r_state;
  deser_state_t      w_state_nxt;
  logic [MOD_W-1:0]  r_cnt;
  logic [MOD_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic [DATA_W-1:0] w_shift;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              w_load;
  logic [DATA_W-1:0] w_word;
  logic [MOD_W-1:0]  w_mod;

  assign w_shift = {r_shreg[DATA_W-2:0], ser_data_i};

  // Collector state, bit counter, shift register and busy flag.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_state <= IDLE_S;
      r_cnt   <= {MOD_W{1'b0}};
      r_shreg <= {DATA_W{1'b0}};
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic and word-completion strobe toward the hold register.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_load      = 1'b0;
    w_word      = {DATA_W{1'b0}};
    w_mod       = {MOD_W{1'b0}};
    case (r_state)
      IDLE_S: begin
        if (ser_data_val_i) begin
          w_shreg_nxt = w_shift;
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = COLLECT_S;
        end else begin
          w_state_nxt = IDLE_S;
        end
      end
      COLLECT_S: begin
        if (ser_data_val_i) begin
          w_shreg_nxt = w_shift;
          // Counter is MOD_W bits, so the DATA_W-th bit wraps it to zero.
          w_cnt_nxt   = r_cnt + 1'b1;
          if (&r_cnt) begin
            w_load      = 1'b1;
            w_word      = w_shift;
            w_state_nxt = IDLE_S;
          end else begin
            w_state_nxt = COLLECT_S;
          end
        end else begin
`ifdef DESERIALIZER_GAP_FLUSH_EN
          w_load      = 1'b1;
          w_word      = r_shreg & low_mask(r_cnt);
          w_mod       = r_cnt;
          w_cnt_nxt   = {MOD_W{1'b0}};
          w_state_nxt = IDLE_S;
`else
          // Gap ignored: partial bits and counter are retained.
          w_state_nxt = COLLECT_S;
`endif
        end
      end
      default: begin
        w_state_nxt = IDLE_S;
        w_cnt_nxt   = {MOD_W{1'b0}};
      end
    endcase
    // A bit taken this cycle keeps busy high even when it completes a word,
    // so a continuous stream never shows a busy gap at word boundaries.
    w_busy_nxt = ser_data_val_i | (w_state_nxt == COLLECT_S);
  end

  assign busy_o = r_busy;

  deserializer_out_buf #(
    .DATA_W (DATA_W),
    .MOD_W  (MOD_W)
  ) u_out_buf (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .i_load     (w_load),
    .i_word     (w_word),
    .i_mod      (w_mod),
    .i_ready    (deser_data_ready_i),
    .o_data     (deser_data_o),
    .o_mod      (deser_data_mod_o),
    .o_val      (deser_data_val_o),
    .o_overflow (overflow_o)
  );

endmodule
